// File: rtl/img_pkg.sv
// Shared types and pixel helpers for the frame-buffer reader pipeline.
package img_pkg;

  localparam int unsigned IMG_W_DEF = 320;
  localparam int unsigned IMG_H_DEF = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Keep the top bits of each RGB565 channel (green drops its LSB and MSB-aligned 4 bits).
  function automatic rgb444_t rgb565_to_444(input logic [15:0] d);
    rgb444_t c;
    c.r = d[15:12];
    c.g = d[10:7];
    c.b = d[4:1];
    return c;
  endfunction

  // (2R + 5G + B) >> 3 using shifts only; the sum peaks at 120, so 7 bits suffice.
  function automatic logic [3:0] rgb_to_gray(input rgb444_t c);
    logic [6:0] sum;
    sum = {2'b00, c.r, 1'b0} + {1'b0, c.g, 2'b00} + {3'b000, c.g} + {3'b000, c.b};
    return 4'(sum >> 3);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Parametrised shift register, cleared on reset; aligns sync/DE/window flags with pixel data.
module delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/img_mem_reader_pipe.sv
// Pipelined frame-buffer reader: VGA timing -> BRAM address -> registered RGB444.
// Optional grayscale output stage enabled by defining IMG_MEM_READER_GRAY_EN.
module img_mem_reader_pipe
  import img_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic              scale_2x,
`ifdef IMG_MEM_READER_GRAY_EN
  input  logic              gray_en,
`endif
  input  logic [15:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic              de_out,
  output logic              h_sync_out,
  output logic              v_sync_out
);

  // row_base reaches IMG_W*IMG_H after the last window line, so give it one spare bit.
  localparam int unsigned RB_W = ADDR_W + 1;
`ifdef IMG_MEM_READER_GRAY_EN
  localparam int unsigned OUT_LAT = MEM_LAT + 3;
`else
  localparam int unsigned OUT_LAT = MEM_LAT + 2;
`endif

  logic              mode_q, mode_d;
  logic [RB_W-1:0]   row_base_q, row_base_d;
  logic              line_phase_q, line_phase_d;
  logic              de_prev_q;
  logic [9:0]        y_prev_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_en_q;
  logic              win_dly;
  rgb444_t           rgb_q, rgb_d;

  logic              frame_start;
  logic              line_end;
  logic              mode_eff;
  logic [RB_W-1:0]   row_eff;
  logic [9:0]        x_src;
  logic              in_win;

`ifdef IMG_MEM_READER_GRAY_EN
  logic              gray_q, gray_d;
  rgb444_t           out_q, out_d;
`endif

  // Frame/line tracking, window test and address generation.
  always_comb begin
    mode_d       = mode_q;
    row_base_d   = row_base_q;
    line_phase_d = line_phase_q;
`ifdef IMG_MEM_READER_GRAY_EN
    gray_d       = gray_q;
`endif

    frame_start = de && !de_prev_q && (y == 10'd0);
    line_end    = !de && de_prev_q && (32'(y_prev_q) < (IMG_H << mode_q));

    // The frame-start cycle already addresses with the newly latched mode and a zero row.
    mode_eff = frame_start ? scale_2x : mode_q;
    row_eff  = frame_start ? '0 : row_base_q;
    x_src    = mode_eff ? (x >> 1) : x;
    in_win   = de && (32'(x) < (IMG_W << mode_eff)) && (32'(y) < (IMG_H << mode_eff));

    mem_addr_d = in_win ? ADDR_W'(row_eff + RB_W'(x_src)) : mem_addr_q;

    if (frame_start) begin
      mode_d       = scale_2x;
      row_base_d   = '0;
      line_phase_d = 1'b0;
`ifdef IMG_MEM_READER_GRAY_EN
      gray_d       = gray_en;
`endif
    end else if (line_end) begin
      if (!mode_q) begin
        row_base_d = row_base_q + RB_W'(IMG_W);
      end else begin
        line_phase_d = !line_phase_q;
        if (line_phase_q) row_base_d = row_base_q + RB_W'(IMG_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= 1'b0;
      row_base_q   <= '0;
      line_phase_q <= 1'b0;
      de_prev_q    <= 1'b0;
      y_prev_q     <= '0;
      mem_addr_q   <= '0;
      rd_en_q      <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      row_base_q   <= row_base_d;
      line_phase_q <= line_phase_d;
      de_prev_q    <= de;
      y_prev_q     <= y;
      mem_addr_q   <= mem_addr_d;
      rd_en_q      <= in_win;
    end
  end

  // Window flag follows the read through the memory latency.
  delay_line #(
    .WIDTH(1),
    .DEPTH(MEM_LAT)
  ) u_win_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rd_en_q),
    .q_o  (win_dly)
  );

  delay_line #(
    .WIDTH(3),
    .DEPTH(OUT_LAT)
  ) u_sync_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  ({de, h_sync, v_sync}),
    .q_o  ({de_out, h_sync_out, v_sync_out})
  );

  // Pixel stage: blank outside the window.
  always_comb begin
    rgb_d = '0;
    if (win_dly) rgb_d = rgb565_to_444(mem_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb_q <= '0;
    else        rgb_q <= rgb_d;
  end

`ifdef IMG_MEM_READER_GRAY_EN
  always_comb begin
    out_d = rgb_q;
    if (gray_q) begin
      out_d.r = rgb_to_gray(rgb_q);
      out_d.g = out_d.r;
      out_d.b = out_d.r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= 1'b0;
      out_q  <= '0;
    end else begin
      gray_q <= gray_d;
      out_q  <= out_d;
    end
  end

  assign r_port = out_q.r;
  assign g_port = out_q.g;
  assign b_port = out_q.b;
`else
  assign r_port = rgb_q.r;
  assign g_port = rgb_q.g;
  assign b_port = rgb_q.b;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_rd_en = rd_en_q;

endmodule

// File: tb/tb_img_mem_reader_pipe.sv
// Directed bench for img_mem_reader_pipe (default build, 320x240, MEM_LAT=1).
module tb_img_mem_reader_pipe;

  localparam int unsigned IMG_W   = 320;
  localparam int unsigned IMG_H   = 240;
  localparam int unsigned MEM_LAT = 1;
  localparam int unsigned ADDR_W  = $clog2(IMG_W * IMG_H);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              de, h_sync, v_sync, scale_2x;
  logic [9:0]        x, y;
  logic [15:0]       mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [3:0]        r_port, g_port, b_port;
  logic              de_out, h_sync_out, v_sync_out;

  int n_checks = 0;
  int n_errs   = 0;

  logic        ovr_en  = 1'b0;
  logic [15:0] ovr_val = 16'hF81F;

  logic        m_mode, m_ph, m_de_prev;
  int          m_rb, m_yprev, m_addr;
  logic [14:0] exp_q[$];

  img_mem_reader_pipe #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .MEM_LAT(MEM_LAT),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .de        (de),
    .x         (x),
    .y         (y),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .scale_2x  (scale_2x),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .r_port    (r_port),
    .g_port    (g_port),
    .b_port    (b_port),
    .de_out    (de_out),
    .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memfn(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] p;
    p = a * ADDR_W'(37);
    return p[15:0] ^ 16'h5A3C;
  endfunction

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) mem_data <= ovr_en ? ovr_val : memfn(mem_addr);

  function automatic logic [14:0] outvec();
    return {de_out, h_sync_out, v_sync_out, r_port, g_port, b_port};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel clock, update the reference model and compare every output.
  task automatic px(input logic d, input int xx, input int yy, input logic sc);
    logic        fs, le, md, w, hs, vs;
    int          rb, a;
    logic [15:0] dat;
    logic [14:0] e;
    fs = d && !m_de_prev && (yy == 0);
    le = !d && m_de_prev && (m_yprev < int'(IMG_H << m_mode));
    md = fs ? sc : m_mode;
    rb = fs ? 0 : m_rb;
    w  = d && (xx < int'(IMG_W << md)) && (yy < int'(IMG_H << md));
    a  = rb + (xx >> md);
    if (w) m_addr = a;
    if (fs) begin
      m_mode = sc;
      m_rb   = 0;
      m_ph   = 1'b0;
    end else if (le) begin
      if (!m_mode) m_rb += IMG_W;
      else begin
        if (m_ph) m_rb += IMG_W;
        m_ph = !m_ph;
      end
    end
    m_de_prev = d;
    m_yprev   = yy;
    hs  = (xx == 700);
    vs  = (yy == 0);
    dat = ovr_en ? ovr_val : memfn(ADDR_W'(a));
    e   = {d, hs, vs, w ? {dat[15:12], dat[10:7], dat[4:1]} : 12'h000};
    de = d; x = 10'(xx); y = 10'(yy); h_sync = hs; v_sync = vs; scale_2x = sc;
    tick();
    check("addr", mem_addr, m_addr);
    check("rd_en", mem_rd_en, w);
    exp_q.push_back(e);
    if (exp_q.size() >= 3) check("pipe", outvec(), exp_q.pop_front());
  endtask

  task automatic line(input int yy, input logic sc, input int n_lo, input int hi0, input int n_hi);
    for (int i = 0; i < n_lo; i++) px(1'b1, i, yy, sc);
    for (int i = 0; i < n_hi; i++) px(1'b1, hi0 + i, yy, sc);
    px(1'b0, 700, yy, sc);
    px(1'b0, 700, yy, sc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    de = 1'b0; x = '0; y = '0; h_sync = 1'b0; v_sync = 1'b0; scale_2x = 1'b0;
    ovr_en = 1'b0;
    tick();
    tick();
    check("rst_pix", outvec(), 0);
    check("rst_addr", {mem_rd_en, mem_addr}, 0);
    rst_n = 1'b1;
    m_mode = 1'b0; m_ph = 1'b0; m_de_prev = 1'b0;
    m_rb = 0; m_yprev = 0; m_addr = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  initial begin
    apply_reset();

    // Single pixel (5,2) in 1x with a known colour.
    ovr_en = 1'b1;
    line(0, 1'b0, 2, 0, 0);
    line(1, 1'b0, 2, 0, 0);
    px(1'b1, 5, 2, 1'b0);
    check("addr_5_2", mem_addr, 645);
    px(1'b0, 700, 2, 1'b0);
    check("de_lat2", de_out, 0);
    px(1'b0, 700, 2, 1'b0);
    check("rgb_lat3", {r_port, g_port, b_port}, 12'hF0F);
    check("de_lat3", de_out, 1);
    ovr_en = 1'b0;

    // 1x frame: window edges on every line, two lines below the window.
    for (int yy = 0; yy < 242; yy++) begin
      line(yy, 1'b0, 2, 318, 4);
      if (yy == 0)   check("1x_y0_end", mem_addr, 319);
      if (yy == 239) check("1x_last", mem_addr, 76799);
    end
    check("1x_hold", {mem_rd_en, mem_addr}, 76799);

    // No display enable at all: output stays black.
    for (int i = 0; i < 20; i++) px(1'b0, i * 30, (i == 5) ? 0 : i, 1'b0);
    check("dark_out", outvec(), 0);

    // 2x frame; scale_2x drops mid-frame and must not take effect yet.
    for (int yy = 0; yy < 482; yy++) begin
      line(yy, (yy < 100) ? 1'b1 : 1'b0, 4, 638, 3);
      if (yy == 0)   check("2x_y0_end", mem_addr, 319);
      if (yy == 1)   check("2x_y1_end", mem_addr, 319);
      if (yy == 2)   check("2x_y2_end", mem_addr, 639);
      if (yy == 101) check("2x_y101_end", mem_addr, 16319);
      if (yy == 479) check("2x_last", mem_addr, 76799);
    end

    // Next frame picks up 1x.
    for (int yy = 0; yy < 3; yy++) begin
      line(yy, 1'b0, 2, 318, 4);
      if (yy == 1) check("new_1x_y1", mem_addr, 639);
    end

    // Asynchronous reset in the middle of a line.
    ovr_en = 1'b1;
    for (int xx = 140; xx <= 150; xx++) px(1'b1, xx, 3, 1'b0);
    check("pre_rst_rgb", {r_port, g_port, b_port}, 12'hF0F);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_pix", outvec(), 0);
    check("async_rst_addr", {mem_rd_en, mem_addr}, 0);
    apply_reset();
    px(1'b0, 700, 3, 1'b0);
    px(1'b1, 0, 0, 1'b0);
    check("post_rst_first", mem_addr, 0);
    px(1'b1, 7, 0, 1'b0);
    check("post_rst_x7", mem_addr, 7);
    for (int i = 0; i < 4; i++) px(1'b0, 700, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
